// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the read-data owner encoding and the byte-mask width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    function automatic int mask_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data handshakes plus the RAM port, bundled for the arbiter.
// master = core + RAM side, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    localparam int MASK_W = mask_w(DATA_W);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [MASK_W-1:0] m_wmask;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, m_wmask
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata, m_wmask
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive fetch denials; force_if rises once STARVE_MAX is reached.
// Cleared by a fetch grant, held while fetch is not requesting.
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam int          SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] MAX_V = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (if_req && starve_q != MAX_V) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_if = (starve_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Data has priority; a starvation guard forces a fetch win after STARVE_MAX denials.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int MASK_W = mask_w(DATA_W);

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;

    logic              force_if;
    logic              d_win;
    logic              if_win;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [MASK_W-1:0] wmask_sel;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .if_gnt   (if_win),
        .force_if (force_if)
    );

    always_comb begin
        d_win      = bus.d_req && !(bus.if_req && force_if) && !rst;
        if_win     = bus.if_req && !d_win && !rst;
        addr_sel   = '0;
        wdata_sel  = '0;
        wmask_sel  = '0;
        owner_d    = OWN_NONE;
        conflict_d = conflict_q;

        if (d_win) begin
            addr_sel  = bus.d_addr;
            wdata_sel = bus.d_wdata;
            if (bus.d_we) begin
                wmask_sel = bus.d_wmask;
            end else begin
                owner_d = OWN_D;
            end
        end else if (if_win) begin
            addr_sel = bus.if_addr;
            owner_d  = OWN_IF;
        end

        if (bus.if_req && bus.d_req && conflict_q != '1) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.if_gnt  = if_win;
    assign bus.d_gnt   = d_win;
    assign bus.m_en    = d_win || if_win;
    assign bus.m_we    = d_win && bus.d_we;
    assign bus.m_addr  = addr_sel;
    assign bus.m_wdata = wdata_sel;
    assign bus.m_wmask = wmask_sel;

    // Reset asserted in the cycle after a grant must swallow that read's response.
    assign bus.if_rvalid = (owner_q == OWN_IF) && !rst;
    assign bus.d_rvalid  = (owner_q == OWN_D) && !rst;
    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_rdata   = bus.m_rdata;

    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: vector table for single accesses, hand sequences for
// arbitration rotation, starvation hold, reset mid-read and counter saturation.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        preload;
    logic [31:0] ram_q;
    logic [31:0] mem [0:255];
    logic [31:0] cnt32;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .CNT_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (cnt32)
    );

    // Narrow-counter copy sees the same traffic; only its counter is checked.
    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .CNT_W(4)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus4),
        .conflict_cnt (cnt4)
    );

    assign bus4.if_req  = bus.if_req;
    assign bus4.if_addr = bus.if_addr;
    assign bus4.d_req   = bus.d_req;
    assign bus4.d_we    = bus.d_we;
    assign bus4.d_addr  = bus.d_addr;
    assign bus4.d_wdata = bus.d_wdata;
    assign bus4.d_wmask = bus.d_wmask;
    assign bus4.m_rdata = bus.m_rdata;
    assign bus.m_rdata  = ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with byte-masked writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h11111111;
            mem[1]  <= 32'h22222222;
            mem[2]  <= 32'h33333333;
            mem[64] <= 32'hCAFE0000;
            ram_q   <= 32'h0;
        end else if (bus.m_en) begin
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_wmask[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end else begin
                ram_q <= mem[bus.m_addr[9:2]];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wmask;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_m_en;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic [3:0]  e_m_wmask;
        logic        e_if_rvalid;
        logic        e_d_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_in(input logic r, input logic ir, input logic [31:0] ia,
                          input logic dr, input logic dw, input logic [31:0] da,
                          input logic [31:0] wd, input logic [3:0] wm);
        rst         = r;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        bus.d_wmask = wm;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Both requesters held; d_req is a read of 0x0, fetch reads 0x8.
    task automatic both_cycle(input logic exp_if_gnt, input string tag);
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check({tag, "_if_gnt"}, 64'(bus.if_gnt), 64'(exp_if_gnt));
        check({tag, "_d_gnt"}, 64'(bus.d_gnt), 64'(!exp_if_gnt));
    endtask

    initial begin
        logic exp_if;
        logic prev_if;

        // Order: rst, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask |
        //        if_gnt, d_gnt, m_en, m_we, m_addr, m_wdata, m_wmask, if_rvalid, d_rvalid, rdata
        vecs[0]  = '{1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0};
        vecs[1]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0};
        vecs[2]  = '{0, 1, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0};
        vecs[3]  = '{0, 1, 32'h4,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 1, 0, 32'h4,   32'h0,        4'h0, 1, 0, 32'h11111111};
        vecs[4]  = '{0, 1, 32'h8,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 1, 0, 32'h8,   32'h0,        4'h0, 1, 0, 32'h22222222};
        vecs[5]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 32'h33333333};
        vecs[6]  = '{0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 0, 0, 32'h0};
        vecs[7]  = '{0, 0, 32'h0,  1, 0, 32'h100, 32'h12345678, 4'hF, 0, 1, 1, 0, 32'h100, 32'h0,        4'h0, 0, 0, 32'h0};
        vecs[8]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'hCAFEBEEF};
        vecs[9]  = '{0, 1, 32'hC,  1, 0, 32'h8,   32'h0,        4'h0, 0, 1, 1, 0, 32'h8,   32'h0,        4'h0, 0, 0, 32'h0};
        vecs[10] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h33333333};
        vecs[11] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0};

        preload = 1'b1;
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req,
                   vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].d_wmask);
            #1;
            check($sformatf("v%0d_if_gnt", i), 64'(bus.if_gnt), 64'(vecs[i].e_if_gnt));
            check($sformatf("v%0d_d_gnt", i), 64'(bus.d_gnt), 64'(vecs[i].e_d_gnt));
            check($sformatf("v%0d_m_en", i), 64'(bus.m_en), 64'(vecs[i].e_m_en));
            check($sformatf("v%0d_m_we", i), 64'(bus.m_we), 64'(vecs[i].e_m_we));
            if (vecs[i].e_m_en) begin
                check($sformatf("v%0d_m_addr", i), 64'(bus.m_addr), 64'(vecs[i].e_m_addr));
                check($sformatf("v%0d_m_wmask", i), 64'(bus.m_wmask), 64'(vecs[i].e_m_wmask));
            end
            if (vecs[i].e_m_we)
                check($sformatf("v%0d_m_wdata", i), 64'(bus.m_wdata), 64'(vecs[i].e_m_wdata));
            check($sformatf("v%0d_if_rvalid", i), 64'(bus.if_rvalid), 64'(vecs[i].e_if_rvalid));
            check($sformatf("v%0d_d_rvalid", i), 64'(bus.d_rvalid), 64'(vecs[i].e_d_rvalid));
            if (vecs[i].e_if_rvalid)
                check($sformatf("v%0d_if_rdata", i), 64'(bus.if_rdata), 64'(vecs[i].e_rdata));
            if (vecs[i].e_d_rvalid)
                check($sformatf("v%0d_d_rdata", i), 64'(bus.d_rdata), 64'(vecs[i].e_rdata));
        end

        // Rotation under constant contention: 4 data grants, then 1 fetch.
        reset_cycle();
        prev_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_if = (i % 5 == 4);
            both_cycle(exp_if, $sformatf("rot%0d", i));
            if (i > 0) begin
                check($sformatf("rot%0d_if_rvalid", i), 64'(bus.if_rvalid), 64'(prev_if));
                check($sformatf("rot%0d_d_rvalid", i), 64'(bus.d_rvalid), 64'(!prev_if));
            end
            prev_if = exp_if;
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("rot_conflict_cnt", 64'(cnt32), 64'd10);
        check("rot_last_if_rvalid", 64'(bus.if_rvalid), 64'd1);

        // Denial count holds while fetch is idle, then resumes from 2.
        reset_cycle();
        both_cycle(1'b0, "hold_a0");
        both_cycle(1'b0, "hold_a1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
            #1;
            check($sformatf("hold_d%0d_d_gnt", i), 64'(bus.d_gnt), 64'd1);
        end
        both_cycle(1'b0, "hold_b0");
        both_cycle(1'b0, "hold_b1");
        both_cycle(1'b1, "hold_b2");

        // Reset right after a granted read: response dropped, arbiter state cleared.
        reset_cycle();
        both_cycle(1'b0, "rmid_k0");
        both_cycle(1'b0, "rmid_k1");
        @(negedge clk);
        set_in(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("rmid_rst_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        check("rmid_rst_d_gnt", 64'(bus.d_gnt), 64'd0);
        check("rmid_rst_if_gnt", 64'(bus.if_gnt), 64'd0);
        check("rmid_rst_m_en", 64'(bus.m_en), 64'd0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("rmid_after_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        check("rmid_after_if_rvalid", 64'(bus.if_rvalid), 64'd0);
        for (int i = 0; i < 5; i++) both_cycle(i == 4, $sformatf("rmid_post%0d", i));

        // Conflict counter saturation on the 4-bit copy.
        reset_cycle();
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i < 20) set_in(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
            else        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            if (i >= 13) begin
                check($sformatf("sat%0d_cnt4", i), 64'(cnt4), (i < 15) ? 64'(i) : 64'd15);
                check($sformatf("sat%0d_cnt32", i), 64'(cnt32), 64'(i));
            end
        end

        // Idle bus stays quiet.
        reset_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            check($sformatf("idle%0d_m_en", i), 64'(bus.m_en), 64'd0);
            check($sformatf("idle%0d_gnt", i), 64'({bus.if_gnt, bus.d_gnt}), 64'd0);
            check($sformatf("idle%0d_rvalid", i), 64'({bus.if_rvalid, bus.d_rvalid}), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
